// File: rtl/sim_axi_pkg.sv
// Shared encodings, FSM states and burst address arithmetic for the AXI4 memory model.
// Addresses are computed in 64 bits; callers truncate to their own address width.
package sim_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Illegal bursts (reserved type, WRAP with a bad length) fall through to INCR addressing.
    function automatic logic [63:0] beat_addr(input logic [63:0] start,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  i);
        logic [63:0] bytes;
        logic [63:0] step;
        logic [63:0] mask;
        bytes = 64'd1 << size;
        step  = {56'd0, i} << size;
        mask  = (({56'd0, len} + 64'd1) << size) - 64'd1;
        if (burst == BURST_FIXED)
            return start;
        if (burst == BURST_WRAP && wrap_len_ok(len))
            return (start & ~mask) | ((start + step) & mask);
        return (start & ~(bytes - 64'd1)) + step;
    endfunction

endpackage

// File: rtl/sim_axi_mem_array.sv
// Byte-strobed word RAM: one write port, one read port with enable-gated registered output.
// A read and write to the same word in one cycle returns the pre-write contents.
module sim_axi_mem_array #(
    parameter int DATA_BITS = 64,
    parameter int DEPTH     = 8192
) (
    input  logic                     clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
    input  logic [DATA_BITS-1:0]     i_wr_data,
    input  logic [DATA_BITS/8-1:0]   i_wr_strb,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [DATA_BITS-1:0]     o_rd_data
);

    localparam int NBYTES = DATA_BITS / 8;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_rd_data;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_wr_strb[b])
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_rd_en)
            r_rd_data <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sim_axi_mem.sv
// Pure-RTL AXI4 slave memory: independent single-outstanding read and write engines
// over a byte-strobed RAM, with FIXED/INCR/WRAP bursts and per-beat SLVERR.
module sim_axi_mem
    import sim_axi_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 64,
    parameter int ID_BITS    = 5,
    parameter int MEM_BYTES  = 65536,
    parameter int RD_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   axi_aw_valid,
    output logic                   axi_aw_ready,
    input  logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
    input  logic [7:0]             axi_aw_bits_len,
    input  logic [2:0]             axi_aw_bits_size,
    input  logic [1:0]             axi_aw_bits_burst,
    input  logic [ID_BITS-1:0]     axi_aw_bits_id,
    input  logic                   axi_w_valid,
    output logic                   axi_w_ready,
    input  logic [DATA_BITS-1:0]   axi_w_bits_data,
    input  logic [DATA_BITS/8-1:0] axi_w_bits_strb,
    input  logic                   axi_w_bits_last,
    output logic                   axi_b_valid,
    input  logic                   axi_b_ready,
    output logic [1:0]             axi_b_bits_resp,
    output logic [ID_BITS-1:0]     axi_b_bits_id,
    input  logic                   axi_ar_valid,
    output logic                   axi_ar_ready,
    input  logic [ADDR_BITS-1:0]   axi_ar_bits_addr,
    input  logic [7:0]             axi_ar_bits_len,
    input  logic [2:0]             axi_ar_bits_size,
    input  logic [1:0]             axi_ar_bits_burst,
    input  logic [ID_BITS-1:0]     axi_ar_bits_id,
    output logic                   axi_r_valid,
    input  logic                   axi_r_ready,
    output logic [DATA_BITS-1:0]   axi_r_bits_data,
    output logic [1:0]             axi_r_bits_resp,
    output logic                   axi_r_bits_last,
    output logic [ID_BITS-1:0]     axi_r_bits_id
);

    localparam int NBYTES   = DATA_BITS / 8;
    localparam int SIZE_MAX = $clog2(NBYTES);
    localparam int DEPTH    = MEM_BYTES / NBYTES;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    function automatic logic beat_err(input logic [ADDR_BITS-1:0] addr,
                                      input logic [2:0]           size,
                                      input logic [1:0]           burst,
                                      input logic [7:0]           len);
        return (64'(addr) >= 64'(MEM_BYTES)) || (int'(size) > SIZE_MAX) ||
               (burst == BURST_RSVD) || (burst == BURST_WRAP && !wrap_len_ok(len));
    endfunction

    // ---------------- write engine ----------------
    wr_state_t              r_wr_state, w_wr_next;
    logic [ADDR_BITS-1:0]   r_aw_addr;
    logic [7:0]             r_aw_len;
    logic [2:0]             r_aw_size;
    logic [1:0]             r_aw_burst;
    logic [ID_BITS-1:0]     r_aw_id;
    logic [7:0]             r_wr_beat;
    logic                   r_wr_err;
    logic [ADDR_BITS-1:0]   w_wr_addr;
    logic                   w_wr_beat_err;
    logic                   w_aw_hs, w_w_hs, w_mem_wr_en;

    assign w_aw_hs       = axi_aw_valid & axi_aw_ready;
    assign w_w_hs        = axi_w_valid & axi_w_ready;
    assign w_wr_addr     = ADDR_BITS'(beat_addr(64'(r_aw_addr), r_aw_len, r_aw_size,
                                                r_aw_burst, r_wr_beat));
    assign w_wr_beat_err = beat_err(w_wr_addr, r_aw_size, r_aw_burst, r_aw_len);
    assign w_mem_wr_en   = w_w_hs & ~w_wr_beat_err;

    always_ff @(posedge clock) begin
        if (reset)
            r_wr_state <= WR_IDLE;
        else
            r_wr_state <= w_wr_next;
    end

    // Readies are masked by reset so nothing is accepted or committed while it is held.
    always_comb begin
        w_wr_next    = r_wr_state;
        axi_aw_ready = 1'b0;
        axi_w_ready  = 1'b0;
        axi_b_valid  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                axi_aw_ready = ~reset;
                if (axi_aw_valid && !reset)
                    w_wr_next = WR_DATA;
            end
            WR_DATA: begin
                axi_w_ready = ~reset;
                if (axi_w_valid && !reset && r_wr_beat == r_aw_len)
                    w_wr_next = WR_RESP;
            end
            WR_RESP: begin
                axi_b_valid = 1'b1;
                if (axi_b_ready)
                    w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_aw_hs) begin
            r_aw_addr  <= axi_aw_bits_addr;
            r_aw_len   <= axi_aw_bits_len;
            r_aw_size  <= axi_aw_bits_size;
            r_aw_burst <= axi_aw_bits_burst;
            r_aw_id    <= axi_aw_bits_id;
            r_wr_beat  <= 8'd0;
            r_wr_err   <= 1'b0;
        end else if (w_w_hs) begin
            r_wr_beat  <= r_wr_beat + 8'd1;
            r_wr_err   <= r_wr_err | w_wr_beat_err;
        end
    end

    assign axi_b_bits_resp = (r_wr_state == WR_RESP && r_wr_err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_b_bits_id   = (r_wr_state == WR_RESP) ? r_aw_id : '0;

    // ---------------- read engine ----------------
    rd_state_t              r_rd_state, w_rd_next;
    logic [ADDR_BITS-1:0]   r_ar_addr;
    logic [7:0]             r_ar_len;
    logic [2:0]             r_ar_size;
    logic [1:0]             r_ar_burst;
    logic [ID_BITS-1:0]     r_ar_id;
    logic [7:0]             r_rd_beat;
    logic                   r_rd_err;
    logic [LAT_W-1:0]       r_lat_cnt;
    logic [ADDR_BITS-1:0]   w_rd_start, w_rd_addr;
    logic [7:0]             w_rd_len, w_rd_idx;
    logic [2:0]             w_rd_size;
    logic [1:0]             w_rd_burst;
    logic                   w_rd_beat_err, w_ar_hs, w_r_hs, w_r_last_beat, w_mem_rd_en;
    logic [DATA_BITS-1:0]   w_mem_rd_data;

    assign w_ar_hs       = axi_ar_valid & axi_ar_ready;
    assign w_r_hs        = axi_r_valid & axi_r_ready;
    assign w_r_last_beat = (r_rd_beat == r_ar_len);

    // The RAM is read one cycle ahead: beat 0 on AR accept, beat i+1 on the beat-i handshake.
    always_comb begin
        w_rd_start = r_ar_addr;
        w_rd_len   = r_ar_len;
        w_rd_size  = r_ar_size;
        w_rd_burst = r_ar_burst;
        w_rd_idx   = r_rd_beat + 8'd1;
        if (r_rd_state == RD_IDLE) begin
            w_rd_start = axi_ar_bits_addr;
            w_rd_len   = axi_ar_bits_len;
            w_rd_size  = axi_ar_bits_size;
            w_rd_burst = axi_ar_bits_burst;
            w_rd_idx   = 8'd0;
        end
    end

    assign w_rd_addr     = ADDR_BITS'(beat_addr(64'(w_rd_start), w_rd_len, w_rd_size,
                                                w_rd_burst, w_rd_idx));
    assign w_rd_beat_err = beat_err(w_rd_addr, w_rd_size, w_rd_burst, w_rd_len);
    assign w_mem_rd_en   = w_ar_hs | (w_r_hs & ~w_r_last_beat);

    always_ff @(posedge clock) begin
        if (reset)
            r_rd_state <= RD_IDLE;
        else
            r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next    = r_rd_state;
        axi_ar_ready = 1'b0;
        axi_r_valid  = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                axi_ar_ready = ~reset;
                if (axi_ar_valid && !reset)
                    w_rd_next = (RD_LATENCY == 1) ? RD_DATA : RD_WAIT;
            end
            RD_WAIT: begin
                if (r_lat_cnt == LAT_W'(RD_LATENCY - 2))
                    w_rd_next = RD_DATA;
            end
            RD_DATA: begin
                axi_r_valid = 1'b1;
                if (axi_r_ready && w_r_last_beat)
                    w_rd_next = RD_IDLE;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_mem_rd_en)
            r_rd_err <= w_rd_beat_err;
        if (w_ar_hs) begin
            r_ar_addr  <= axi_ar_bits_addr;
            r_ar_len   <= axi_ar_bits_len;
            r_ar_size  <= axi_ar_bits_size;
            r_ar_burst <= axi_ar_bits_burst;
            r_ar_id    <= axi_ar_bits_id;
            r_rd_beat  <= 8'd0;
            r_lat_cnt  <= '0;
        end else begin
            if (w_r_hs)
                r_rd_beat <= r_rd_beat + 8'd1;
            if (r_rd_state == RD_WAIT)
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end
    end

    assign axi_r_bits_data = (r_rd_state == RD_DATA && !r_rd_err) ? w_mem_rd_data : '0;
    assign axi_r_bits_resp = (r_rd_state == RD_DATA && r_rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_r_bits_last = (r_rd_state == RD_DATA) && w_r_last_beat;
    assign axi_r_bits_id   = (r_rd_state == RD_DATA) ? r_ar_id : '0;

    sim_axi_mem_array #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_array (
        .clock     (clock),
        .i_wr_en   (w_mem_wr_en),
        .i_wr_idx  (w_wr_addr[SIZE_MAX +: IDX_W]),
        .i_wr_data (axi_w_bits_data),
        .i_wr_strb (axi_w_bits_strb),
        .i_rd_en   (w_mem_rd_en),
        .i_rd_idx  (w_rd_addr[SIZE_MAX +: IDX_W]),
        .o_rd_data (w_mem_rd_data)
    );

endmodule

// File: tb/tb_sim_axi_mem.sv
// Directed bench for sim_axi_mem: bursts, wrap, narrow strobes, SLVERR, back-pressure, reset.
module tb_sim_axi_mem;

    localparam int AB  = 32;
    localparam int DB  = 64;
    localparam int IB  = 5;
    localparam int MB  = 4096;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          axi_aw_valid, axi_aw_ready;
    logic [AB-1:0] axi_aw_bits_addr;
    logic [7:0]    axi_aw_bits_len;
    logic [2:0]    axi_aw_bits_size;
    logic [1:0]    axi_aw_bits_burst;
    logic [IB-1:0] axi_aw_bits_id;
    logic          axi_w_valid, axi_w_ready;
    logic [DB-1:0] axi_w_bits_data;
    logic [7:0]    axi_w_bits_strb;
    logic          axi_w_bits_last;
    logic          axi_b_valid, axi_b_ready;
    logic [1:0]    axi_b_bits_resp;
    logic [IB-1:0] axi_b_bits_id;
    logic          axi_ar_valid, axi_ar_ready;
    logic [AB-1:0] axi_ar_bits_addr;
    logic [7:0]    axi_ar_bits_len;
    logic [2:0]    axi_ar_bits_size;
    logic [1:0]    axi_ar_bits_burst;
    logic [IB-1:0] axi_ar_bits_id;
    logic          axi_r_valid, axi_r_ready;
    logic [DB-1:0] axi_r_bits_data;
    logic [1:0]    axi_r_bits_resp;
    logic          axi_r_bits_last;
    logic [IB-1:0] axi_r_bits_id;

    sim_axi_mem #(.ADDR_BITS(AB), .DATA_BITS(DB), .ID_BITS(IB), .MEM_BYTES(MB),
                  .RD_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
        .axi_aw_bits_addr(axi_aw_bits_addr), .axi_aw_bits_len(axi_aw_bits_len),
        .axi_aw_bits_size(axi_aw_bits_size), .axi_aw_bits_burst(axi_aw_bits_burst),
        .axi_aw_bits_id(axi_aw_bits_id),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_w_bits_data(axi_w_bits_data), .axi_w_bits_strb(axi_w_bits_strb),
        .axi_w_bits_last(axi_w_bits_last),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
        .axi_b_bits_resp(axi_b_bits_resp), .axi_b_bits_id(axi_b_bits_id),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
        .axi_ar_bits_addr(axi_ar_bits_addr), .axi_ar_bits_len(axi_ar_bits_len),
        .axi_ar_bits_size(axi_ar_bits_size), .axi_ar_bits_burst(axi_ar_bits_burst),
        .axi_ar_bits_id(axi_ar_bits_id),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
        .axi_r_bits_data(axi_r_bits_data), .axi_r_bits_resp(axi_r_bits_resp),
        .axi_r_bits_last(axi_r_bits_last), .axi_r_bits_id(axi_r_bits_id)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] wb_data [16];
    logic [7:0]  wb_strb [16];
    logic [63:0] rb_data [16];
    logic [1:0]  rb_resp [16];
    logic        rb_last [16];
    logic [4:0]  rb_id   [16];
    int          rb_n, rb_lat;
    logic [1:0]  b_resp;
    logic [4:0]  b_id;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [4:0] id);
        @(negedge clock);
        axi_aw_bits_addr = addr; axi_aw_bits_len = len; axi_aw_bits_size = size;
        axi_aw_bits_burst = burst; axi_aw_bits_id = id; axi_aw_valid = 1'b1;
        for (int k = 0; k < 50 && !axi_aw_ready; k++) @(negedge clock);
        chk("aw_ready", 64'(axi_aw_ready), 64'd1);
        @(posedge clock); #1;
        axi_aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        @(negedge clock);
        axi_w_bits_data = data; axi_w_bits_strb = strb; axi_w_bits_last = last;
        axi_w_valid = 1'b1;
        for (int k = 0; k < 50 && !axi_w_ready; k++) @(negedge clock);
        chk("w_ready", 64'(axi_w_ready), 64'd1);
        @(posedge clock); #1;
        axi_w_valid = 1'b0;
    endtask

    task automatic b_recv();
        @(negedge clock);
        axi_b_ready = 1'b1;
        for (int k = 0; k < 50 && !axi_b_valid; k++) @(negedge clock);
        chk("b_valid", 64'(axi_b_valid), 64'd1);
        b_resp = axi_b_bits_resp;
        b_id   = axi_b_bits_id;
        @(posedge clock); #1;
        axi_b_ready = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [4:0] id);
        aw_send(addr, len, size, burst, id);
        for (int i = 0; i <= int'(len); i++) w_send(wb_data[i], wb_strb[i], i == int'(len));
        b_recv();
    endtask

    // Collects a whole read burst; at beat stall_beat r_ready is held low 5 cycles and
    // the presented beat must stay frozen.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [4:0] id, input int stall_beat);
        int cyc, guard, stall_cnt;
        logic [63:0] s_data;
        logic s_last;
        @(negedge clock);
        axi_ar_bits_addr = addr; axi_ar_bits_len = len; axi_ar_bits_size = size;
        axi_ar_bits_burst = burst; axi_ar_bits_id = id; axi_ar_valid = 1'b1;
        for (int k = 0; k < 50 && !axi_ar_ready; k++) @(negedge clock);
        chk("ar_ready", 64'(axi_ar_ready), 64'd1);
        @(posedge clock); #1;
        axi_ar_valid = 1'b0;
        axi_r_ready  = (stall_beat != 0);
        rb_n = 0; rb_lat = -1; cyc = 1; guard = 0; stall_cnt = 0;
        s_data = '0; s_last = 1'b0;
        while (rb_n <= int'(len) && guard < 200) begin
            @(negedge clock);
            if (axi_r_valid) begin
                if (rb_lat < 0) rb_lat = cyc;
                if (!axi_r_ready) begin
                    if (stall_cnt == 0) begin
                        s_data = axi_r_bits_data;
                        s_last = axi_r_bits_last;
                    end else begin
                        chk("stall_data", axi_r_bits_data, s_data);
                        chk("stall_last", 64'(axi_r_bits_last), 64'(s_last));
                    end
                    stall_cnt++;
                    if (stall_cnt == 5) axi_r_ready = 1'b1;
                end
                if (axi_r_ready) begin
                    rb_data[rb_n] = axi_r_bits_data;
                    rb_resp[rb_n] = axi_r_bits_resp;
                    rb_last[rb_n] = axi_r_bits_last;
                    rb_id[rb_n]   = axi_r_bits_id;
                    rb_n++;
                end
            end
            @(posedge clock); #1;
            cyc++; guard++;
            if (rb_n == stall_beat && stall_cnt == 0) axi_r_ready = 1'b0;
        end
        axi_r_ready = 1'b0;
        chk("r_beats", 64'(rb_n), 64'(int'(len) + 1));
        @(negedge clock);
        chk("r_idle_after", 64'(axi_r_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        axi_aw_valid = 0; axi_aw_bits_addr = '0; axi_aw_bits_len = '0; axi_aw_bits_size = '0;
        axi_aw_bits_burst = '0; axi_aw_bits_id = '0;
        axi_w_valid = 0; axi_w_bits_data = '0; axi_w_bits_strb = '0; axi_w_bits_last = 0;
        axi_b_ready = 0;
        axi_ar_valid = 0; axi_ar_bits_addr = '0; axi_ar_bits_len = '0; axi_ar_bits_size = '0;
        axi_ar_bits_burst = '0; axi_ar_bits_id = '0;
        axi_r_ready = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_aw_ready", 64'(axi_aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(axi_ar_ready), 64'd0);
        chk("rst_w_ready",  64'(axi_w_ready),  64'd0);
        chk("rst_b_valid",  64'(axi_b_valid),  64'd0);
        chk("rst_r_valid",  64'(axi_r_valid),  64'd0);
        chk("rst_r_data",   axi_r_bits_data,   64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_aw_ready", 64'(axi_aw_ready), 64'd1);

        // INCR burst write/read round trip
        for (int i = 0; i < 4; i++) begin wb_data[i] = 64'(i + 1); wb_strb[i] = 8'hFF; end
        write_burst(32'h100, 8'd3, 3'd3, 2'd1, 5'd5);
        chk("b_resp_incr", 64'(b_resp), 64'd0);
        chk("b_id_incr",   64'(b_id),   64'd5);
        read_burst(32'h100, 8'd3, 3'd3, 2'd1, 5'd9, -1);
        chk("r_latency", 64'(rb_lat), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("r_incr_data", rb_data[i], 64'(i + 1));
            chk("r_incr_last", 64'(rb_last[i]), 64'(i == 3));
            chk("r_incr_resp", 64'(rb_resp[i]), 64'd0);
        end
        chk("r_incr_id", 64'(rb_id[0]), 64'd9);

        // WRAP from 0x118 visits 0x118,0x100,0x108,0x110
        read_burst(32'h118, 8'd3, 3'd3, 2'd2, 5'd1, -1);
        chk("r_wrap0", rb_data[0], 64'd4);
        chk("r_wrap1", rb_data[1], 64'd1);
        chk("r_wrap2", rb_data[2], 64'd2);
        chk("r_wrap3", rb_data[3], 64'd3);

        // FIXED burst rereads the start word
        read_burst(32'h108, 8'd2, 3'd3, 2'd0, 5'd2, -1);
        chk("r_fixed2", rb_data[2], 64'd2);

        // Narrow strobe over zeroed word
        wb_data[0] = 64'd0; wb_strb[0] = 8'hFF;
        write_burst(32'h200, 8'd0, 3'd3, 2'd1, 5'd3);
        wb_data[0] = 64'hAABBCCDD_11223344; wb_strb[0] = 8'h0F;
        write_burst(32'h200, 8'd0, 3'd3, 2'd1, 5'd3);
        read_burst(32'h200, 8'd0, 3'd3, 2'd1, 5'd3, -1);
        chk("r_strb", rb_data[0], 64'h00000000_11223344);
        chk("r_strb_last", 64'(rb_last[0]), 64'd1);

        // Out-of-range accesses
        wb_data[0] = 64'hDEADBEEF_00000001; wb_strb[0] = 8'hFF;
        write_burst(32'h0, 8'd0, 3'd3, 2'd1, 5'd4);
        read_burst(32'(MB), 8'd1, 3'd3, 2'd1, 5'd6, -1);
        for (int i = 0; i < 2; i++) begin
            chk("r_oob_resp", 64'(rb_resp[i]), 64'd2);
            chk("r_oob_data", rb_data[i], 64'd0);
        end
        wb_data[0] = 64'h12345678_9ABCDEF0; wb_strb[0] = 8'hFF;
        write_burst(32'(MB), 8'd0, 3'd3, 2'd1, 5'd7);
        chk("b_oob_resp", 64'(b_resp), 64'd2);
        chk("b_oob_id", 64'(b_id), 64'd7);
        read_burst(32'h0, 8'd0, 3'd3, 2'd1, 5'd0, -1);
        chk("r_addr0_kept", rb_data[0], 64'hDEADBEEF_00000001);
        chk("r_addr0_resp", 64'(rb_resp[0]), 64'd0);

        // Oversize beat and bad WRAP length
        write_burst(32'h300, 8'd0, 3'd4, 2'd1, 5'd8);
        chk("b_size_resp", 64'(b_resp), 64'd2);
        read_burst(32'h100, 8'd2, 3'd3, 2'd2, 5'd1, -1);
        chk("r_badwrap_resp", 64'(rb_resp[1]), 64'd2);
        chk("r_badwrap_data", rb_data[1], 64'd0);

        // Back-pressure mid-burst
        read_burst(32'h100, 8'd3, 3'd3, 2'd1, 5'd2, 1);
        for (int i = 0; i < 4; i++) chk("r_stall_data", rb_data[i], 64'(i + 1));
        chk("r_stall_last", 64'(rb_last[3]), 64'd1);

        // Reset during the third beat of a 4-beat write
        aw_send(32'h400, 8'd3, 3'd3, 2'd1, 5'd10);
        w_send(64'hA0, 8'hFF, 1'b0);
        w_send(64'hA1, 8'hFF, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_w_ready",  64'(axi_w_ready),  64'd0);
        chk("mid_rst_aw_ready", 64'(axi_aw_ready), 64'd0);
        chk("mid_rst_b_valid",  64'(axi_b_valid),  64'd0);
        chk("mid_rst_b_id",     64'(axi_b_bits_id), 64'd0);
        reset = 1'b0;
        wb_data[0] = 64'h77; wb_strb[0] = 8'hFF;
        write_burst(32'h500, 8'd0, 3'd3, 2'd1, 5'd11);
        chk("post_rst_b_resp", 64'(b_resp), 64'd0);
        chk("post_rst_b_id", 64'(b_id), 64'd11);
        read_burst(32'h400, 8'd3, 3'd3, 2'd1, 5'd0, -1);
        chk("rst_kept0", rb_data[0], 64'hA0);
        chk("rst_kept1", rb_data[1], 64'hA1);
        read_burst(32'h500, 8'd0, 3'd3, 2'd1, 5'd0, -1);
        chk("post_rst_data", rb_data[0], 64'h77);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sim_axi_mem.md
Name: sim_axi_mem

Overview:
- Pure-RTL AXI4 slave memory model for simulation; replaces the DPI-backed DRAM model where no C++ backing store is wanted (lint, formal, fast RTL-only sims).
- Generalised over data width, ID width, memory size and read latency.
- Supports FIXED/INCR/WRAP bursts, narrow transfers, strobes and SLVERR for bad accesses.
- Sits at a memory port of the test harness.

Parameters:
ADDR_BITS, 32, AXI address width
DATA_BITS, 64, data width; power of 2, 32..512
ID_BITS, 5, AXI ID width
MEM_BYTES, 65536, backing-store size; power of 2, multiple of DATA_BITS/8
RD_LATENCY, 2, cycles from AR handshake to first R valid; >=1

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
axi_aw_valid  in  1  write address valid
axi_aw_ready  out  1  write address ready
axi_aw_bits_addr  in  ADDR_BITS  byte address
axi_aw_bits_len  in  8  beats-1
axi_aw_bits_size  in  3  log2 bytes/beat
axi_aw_bits_burst  in  2  0 FIXED, 1 INCR, 2 WRAP
axi_aw_bits_id  in  ID_BITS  transaction ID
axi_w_valid  in  1  write data valid
axi_w_ready  out  1  write data ready
axi_w_bits_data  in  DATA_BITS  write data
axi_w_bits_strb  in  DATA_BITS/8  byte strobes
axi_w_bits_last  in  1  last beat
axi_b_valid  out  1  write response valid
axi_b_ready  in  1  write response ready
axi_b_bits_resp  out  2  OKAY=0/SLVERR=2
axi_b_bits_id  out  ID_BITS  echoed AW id
axi_ar_valid  in  1  read address valid
axi_ar_ready  out  1  read address ready
axi_ar_bits_addr  in  ADDR_BITS  byte address
axi_ar_bits_len  in  8  beats-1
axi_ar_bits_size  in  3  log2 bytes/beat
axi_ar_bits_burst  in  2  burst type
axi_ar_bits_id  in  ID_BITS  transaction ID
axi_r_valid  out  1  read data valid
axi_r_ready  in  1  read data ready
axi_r_bits_data  out  DATA_BITS  read data
axi_r_bits_resp  out  2  OKAY/SLVERR
axi_r_bits_last  out  1  last beat
axi_r_bits_id  out  ID_BITS  echoed AR id

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- Reset: all ready/valid outputs are 0; resp, id, data and last are 0. Both FSMs go to IDLE. The memory array is NOT cleared. Reset mid-burst abandons the burst with no response, and any writes already committed stay committed.
- Independent read and write engines, one outstanding transaction each. No ordering between channels.
- Same-cycle write and read to one word: the read returns the old data.
- Write FSM:
  - IDLE: aw_ready=1. AW handshake latches addr/len/size/burst/id -> DATA.
  - DATA: w_ready=1. Each W handshake commits the strobed bytes at the current beat address. After beat len -> RESP. w_last is ignored for counting.
  - RESP: b_valid=1; hold until b_ready -> IDLE.
  - Throughput: AW accepted cycle N, first W accepted no earlier than N+1.
- Read FSM:
  - IDLE: ar_ready=1. Handshake -> WAIT.
  - WAIT: counts RD_LATENCY-1 cycles -> DATA, so r_valid rises RD_LATENCY cycles after the AR handshake.
  - DATA: r_valid=1; r_data/resp/last stay stable while r_ready=0. Beat advances on handshake. r_last=1 on beat len; its handshake -> IDLE.
- Beat address:
  - FIXED: start address every beat.
  - INCR: aligned start + i*(1<<size).
  - WRAP: container = (len+1)<<size; address wraps at container-aligned boundaries.
  - Width rule: addresses are computed in ADDR_BITS with no carry out.
- Narrow transfers: the addressed word is floor(addr/(DATA_BITS/8)). Read returns the full word; the master selects lanes. Write honours strb as given.
- SLVERR, per beat: the beat address is >= MEM_BYTES, size > log2(DATA_BITS/8), burst=3, or WRAP with len not in {1,3,7,15}.
  - On SLVERR, writes are dropped and read data is 0.
  - B resp = SLVERR if any beat erred.
  - The illegal cases use INCR addressing.

Decomposition:
- Shared package sim_axi_pkg: burst encodings, resp encodings, read/write FSM state enums, and a function beat_addr(start,len,size,burst,i).
- One sub-module, sim_axi_mem_array: byte-strobed RAM with one read port and one write port, registered read data.

Test Plan:
- INCR write len=3 size=3 at 0x100 with data 1..4 and strb=0xFF, then read the same -> B OKAY id echoed; R beats 1,2,3,4; r_last only on beat 4; first r_valid exactly RD_LATENCY=2 cycles after AR.
- WRAP read len=3 size=3 at 0x118 -> beat addresses 0x118, 0x100, 0x108, 0x110.
- Write 0xAABBCCDD_11223344 strb=0x0F at 0x200 over prior zeros, then read -> 0x00000000_11223344.
- Read at MEM_BYTES len=1 -> two beats resp=2 data=0; write at MEM_BYTES -> B resp=2, and a read of address 0 is unchanged.
- r_ready held low 5 cycles mid-burst -> r_data/r_last stable; no beat lost or duplicated.
- Assert reset during W beat 2 of 4 -> outputs 0 next cycle; a new AW is accepted after deassert; beats 0-1 remain written.
